// File: rtl/fp32_product_accumulator.sv
// fp32_product_accumulator: multi-cycle FP32 summation of a product stream.
// Each accepted term goes through ALIGN, ADD and NORM, one cycle each.
// After the term tagged in_last, the total is held on the output handshake
// until the consumer takes it. Exponent 0 is read as a signed zero. Exponent
// 255 is read as Inf.
module fp32_product_accumulator #(
   parameter int unsigned GUARD_BITS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_ovf
);

   localparam int unsigned MW = 24 + GUARD_BITS;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t          state, state_n;
   logic [31:0]     acc, term, inf_word;
   logic            ovf, last, a_sign, sub_op, inf_hit;
   logic [7:0]      a_exp;
   logic [MW-1:0]   a_mant, b_mant;
   logic [MW:0]     sum;

   // ALIGN datapath signals
   logic [7:0]      acc_e, t_e, big_e, small_e, sh;
   logic [22:0]     acc_f, t_f;
   logic            t_bigger, acc_inf, t_inf;
   logic [31:0]     big_w, small_w;
   logic [MW-1:0]   big_m, small_m, lost, al_b;

   // NORM datapath signals
   logic [4:0]      lz;
   logic            found, rnd;
   logic [MW-1:0]   nm;
   logic [23:0]     mant24;
   logic [24:0]     r25;
   logic [22:0]     frac;
   logic signed [9:0] e_n;
   logic [31:0]     norm_res;
   logic            norm_ovf;

   // Handshake outputs: accept only in IDLE. The result is shown only in DONE.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      out_data  = (state == DONE) ? acc : '0;
      out_ovf   = (state == DONE) ? ovf : 1'b0;
   end

   // Next-state logic of the term-processing sequencer
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (in_valid) state_n = ALIGN;
         ALIGN:   state_n = ADD;
         ADD:     state_n = NORM;
         NORM:    state_n = last ? DONE : IDLE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Unpack both operands. Order them by magnitude, then align the smaller one with sticky collection.
   always_comb begin
      acc_e    = acc[30:23];
      t_e      = term[30:23];
      acc_f    = (acc_e == 8'd0) ? '0 : acc[22:0];
      t_f      = (t_e == 8'd0) ? '0 : term[22:0];
      acc_inf  = (acc_e == 8'hFF);
      t_inf    = (t_e == 8'hFF);
      t_bigger = {t_e, t_f} > {acc_e, acc_f};
      big_w    = t_bigger ? term : acc;
      small_w  = t_bigger ? acc : term;
      big_e    = big_w[30:23];
      small_e  = small_w[30:23];
      big_m    = {(big_e != 8'd0), ((big_e == 8'd0) ? 23'd0 : big_w[22:0]), {GUARD_BITS{1'b0}}};
      small_m  = {(small_e != 8'd0), ((small_e == 8'd0) ? 23'd0 : small_w[22:0]), {GUARD_BITS{1'b0}}};
      sh       = big_e - small_e;
      lost     = '0;
      if (sh >= 8'(MW)) begin
         al_b = {{(MW-1){1'b0}}, |small_m};
      end else begin
         lost = small_m & ~({MW{1'b1}} << sh);
         al_b = (small_m >> sh) | {{(MW-1){1'b0}}, |lost};
      end
   end

   // Normalize the raw sum, round to nearest even, and range-check the exponent
   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MW; i++) begin
         if (!found) begin
            if (sum[MW-1-i]) found = 1'b1;
            else             lz = lz + 5'd1;
         end
      end
      if (sum[MW]) begin
         nm  = {sum[MW:2], sum[1] | sum[0]};
         e_n = 10'(a_exp) + 10'sd1;
      end else begin
         nm  = sum[MW-1:0] << lz;
         e_n = 10'(a_exp) - 10'(lz);
      end
      mant24 = nm[MW-1:GUARD_BITS];
      rnd    = nm[GUARD_BITS-1] & ((|nm[GUARD_BITS-2:0]) | mant24[0]);
      r25    = {1'b0, mant24} + {24'd0, rnd};
      // A rounding carry leaves 1.000..0, so drop one bit and bump the exponent
      frac   = r25[24] ? r25[23:1] : r25[22:0];
      if (r25[24]) e_n = e_n + 10'sd1;
      norm_ovf = 1'b0;
      if (inf_hit) begin
         norm_res = inf_word;
         norm_ovf = 1'b1;
      end else if (sum == '0) begin
         norm_res = '0;
      end else if (e_n >= 10'sd255) begin
         norm_res = {a_sign, 8'hFF, 23'd0};
         norm_ovf = 1'b1;
      end else if (e_n <= 10'sd0) begin
         norm_res = {a_sign, 31'd0};
      end else begin
         norm_res = {a_sign, e_n[7:0], frac};
      end
   end

   // State register and per-stage pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         ovf      <= 1'b0;
         term     <= '0;
         last     <= 1'b0;
         a_sign   <= 1'b0;
         a_exp    <= '0;
         a_mant   <= '0;
         b_mant   <= '0;
         sub_op   <= 1'b0;
         inf_hit  <= 1'b0;
         inf_word <= '0;
         sum      <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  term <= in_data;
                  last <= in_last;
               end
            end
            ALIGN: begin
               a_sign   <= big_w[31];
               a_exp    <= big_e;
               a_mant   <= big_m;
               b_mant   <= al_b;
               sub_op   <= big_w[31] ^ small_w[31];
               inf_hit  <= acc_inf | t_inf;
               // An Inf already in acc wins, so the first Inf seen keeps its sign
               inf_word <= acc_inf ? acc : {term[31], 8'hFF, 23'd0};
            end
            ADD: begin
               sum <= sub_op ? ({1'b0, a_mant} - {1'b0, b_mant})
                             : ({1'b0, a_mant} + {1'b0, b_mant});
            end
            NORM: begin
               acc <= norm_res;
               ovf <= ovf | norm_ovf;
            end
            DONE: begin
               if (out_ready) begin
                  acc <= '0;
                  ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_product_accumulator.sv
// Directed testbench for fp32_product_accumulator. The expected values are hand-computed FP32 sums.
module tb_fp32_product_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_ovf;

   int errors = 0;
   int checks = 0;

   fp32_product_accumulator #(.GUARD_BITS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Watchdog: stop a hung run
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
      end
   endtask

   // Present one term. Wait (bounded) for in_ready, then complete the handshake. The task returns at the negedge after the accept edge.
   task automatic send(input logic [31:0] d, input logic l, input string tag);
      int n;
      n = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept_wait"}, 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
   endtask

   // Wait (bounded) for out_valid, check data and ovf, then take the result
   task automatic get_result(input string tag, input logic [31:0] exp_d, input logic exp_o);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid_wait"}, 32'(n < 50), 32'd1);
      chk({tag, "_data"}, out_data, exp_d);
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_o));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready_low", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_data", out_data, 32'h0);
      chk("post_rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // 2.0 + 3.0 = 5.0. out_valid rises on the 4th edge, counting the accept edge.
      send(32'h40000000, 1'b0, "t1a");
      send(32'h40400000, 1'b1, "t1b");
      @(negedge clk);
      @(negedge clk);
      chk("t1_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid_latency", 32'(out_valid), 32'd1);
      get_result("t1", 32'h40A00000, 1'b0);

      // 1.0 + -1.0 gives +0 exactly
      send(32'h3F800000, 1'b0, "t2a");
      send(32'hBF800000, 1'b1, "t2b");
      get_result("t2", 32'h00000000, 1'b0);

      // 1.0 + 2^-24 is a tie and rounds to even
      send(32'h3F800000, 1'b0, "t3a");
      send(32'h33800000, 1'b1, "t3b");
      get_result("t3_tie", 32'h3F800000, 1'b0);

      // 1.0 + 1.5*2^-24 is above half an ulp, so it rounds up
      send(32'h3F800000, 1'b0, "t3c");
      send(32'h33C00000, 1'b1, "t3d");
      get_result("t3_up", 32'h3F800001, 1'b0);

      // Exponent overflow saturates to +Inf and sets ovf
      send(32'h7F000000, 1'b0, "t4a");
      send(32'h7F000000, 1'b1, "t4b");
      get_result("t4_ovf", 32'h7F800000, 1'b1);

      // The next accumulation starts from acc=0 with ovf clear
      send(32'h3F800000, 1'b1, "t4c");
      get_result("t4_clear", 32'h3F800000, 1'b0);

      // Effective subtraction: 3.0 + -1.0 = 2.0
      send(32'h40400000, 1'b0, "sub_a");
      send(32'hBF800000, 1'b1, "sub_b");
      get_result("sub", 32'h40000000, 1'b0);

      // An Inf term replaces the sum with an Inf of the term's sign
      send(32'h40000000, 1'b0, "inf_a");
      send(32'hFF800000, 1'b1, "inf_b");
      get_result("inf_term", 32'hFF800000, 1'b1);

      // Inf is sticky. A later opposite-sign Inf keeps the first Inf's sign.
      send(32'h7F800000, 1'b0, "inf_c");
      send(32'h3F800000, 1'b0, "inf_d");
      send(32'hFF800000, 1'b1, "inf_e");
      get_result("inf_sticky", 32'h7F800000, 1'b1);

      // A single denormal term is flushed to +0
      send(32'h00400000, 1'b1, "dnrm");
      get_result("dnrm", 32'h00000000, 1'b0);

      // Three terms 1+2+4 = 7, then 10 cycles of back-pressure with a pending input
      send(32'h3F800000, 1'b0, "bp_a");
      send(32'h40000000, 1'b0, "bp_b");
      send(32'h40800000, 1'b1, "bp_c");
      for (int i = 0; i < 8 && out_valid !== 1'b1; i++) @(negedge clk);
      in_data  = 32'h3F800000;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_data_hold", out_data, 32'h40E00000);
         chk("bp_valid_hold", 32'(out_valid), 32'd1);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      get_result("bp", 32'h40E00000, 1'b0);
      send(32'h3F800000, 1'b1, "bp_next");
      get_result("bp_next", 32'h3F800000, 1'b0);

      // Reset while the first term is in ADD discards the partial sum
      send(32'h40000000, 1'b0, "r6a");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("r6_in_ready_in_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("r6_out_valid", 32'(out_valid), 32'd0);
      chk("r6_in_ready", 32'(in_ready), 32'd1);
      send(32'h40000000, 1'b1, "r6b");
      get_result("r6", 32'h40000000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
